// File: rtl/conv3x3_pkg.sv
// Shared types and helpers for the 3x3 edge/sharpen pipeline.
// Optional macro CONV3X3_ABS_EN (see conv3x3_edge_pipe) does not affect this file.
package conv3x3_pkg;

  typedef enum logic [1:0] {
    MODE_LAP8  = 2'd0,
    MODE_LAP4  = 2'd1,
    MODE_SHARP = 2'd2,
    MODE_PASS  = 2'd3
  } mode_e;

  localparam int unsigned ACC_MAX = 32;

  function automatic int acc_w_def(input int pix_w);
    return pix_w + 5;
  endfunction

  // Saturate a signed accumulator into [0, 2^pix_w-1]; callers keep the low pix_w bits.
  function automatic logic [ACC_MAX-1:0] clamp_u(input logic signed [ACC_MAX-1:0] acc,
                                                 input int unsigned pix_w);
    logic signed [ACC_MAX-1:0] max_v;
    max_v = (ACC_MAX'(1) << pix_w) - ACC_MAX'(1);
    if (acc < 0)
      clamp_u = '0;
    else if (acc > max_v)
      clamp_u = max_v;
    else
      clamp_u = acc;
  endfunction

endpackage

// File: rtl/conv3x3_gray.sv
// Registered grayscale conversion of one CH-channel pixel, advancing when i_en is high.
module conv3x3_gray
  import conv3x3_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CH    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [CH*PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0]    o_gray
);

  logic [PIX_W-1:0] w_gray;
  logic [PIX_W-1:0] r_gray;

  generate
    if (CH >= 3) begin : g_rgb
      logic [PIX_W+1:0] w_sum;
      assign w_sum = {2'b00, i_pix[PIX_W-1:0]}
                   + {1'b0, i_pix[2*PIX_W-1:PIX_W], 1'b0}
                   + {2'b00, i_pix[3*PIX_W-1:2*PIX_W]};
      assign w_gray = w_sum[PIX_W+1:2];
    end else begin : g_mono
      assign w_gray = i_pix[PIX_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_gray <= '0;
    else if (i_en)
      r_gray <= w_gray;
  end

  assign o_gray = r_gray;

endmodule

// File: rtl/conv3x3_edge_pipe.sv
// 3x3 gray edge/sharpen filter: S1 gray, S2 kernel, S3 clamp, global stall on output backpressure.
// Define CONV3X3_ABS_EN to fold negative kernel results to magnitude (modes 0-2) before clamping.
module conv3x3_edge_pipe
  import conv3x3_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CH    = 3,
  parameter int ACC_W = acc_w_def(PIX_W)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CH*PIX_W-1:0] D00IN,
  input  logic [CH*PIX_W-1:0] D01IN,
  input  logic [CH*PIX_W-1:0] D02IN,
  input  logic [CH*PIX_W-1:0] D10IN,
  input  logic [CH*PIX_W-1:0] D11IN,
  input  logic [CH*PIX_W-1:0] D12IN,
  input  logic [CH*PIX_W-1:0] D20IN,
  input  logic [CH*PIX_W-1:0] D21IN,
  input  logic [CH*PIX_W-1:0] D22IN,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic                in_eol,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eol,
  output logic [CH*PIX_W-1:0] Dout
);

  logic  w_en, w_accept;
  mode_e r_mode_q, w_mode_cur;

  assign w_en       = ~out_valid | out_ready;
  assign in_ready   = w_en;
  assign w_accept   = in_valid & w_en;
  // An SOF beat uses its own mode, not the previously latched one.
  assign w_mode_cur = (w_accept & in_sof) ? mode_e'(mode) : r_mode_q;

  logic [CH*PIX_W-1:0] w_win [9];
  logic [PIX_W-1:0]    w_g   [9];

  assign w_win[0] = D00IN;
  assign w_win[1] = D01IN;
  assign w_win[2] = D02IN;
  assign w_win[3] = D10IN;
  assign w_win[4] = D11IN;
  assign w_win[5] = D12IN;
  assign w_win[6] = D20IN;
  assign w_win[7] = D21IN;
  assign w_win[8] = D22IN;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_gray
      conv3x3_gray #(.PIX_W(PIX_W), .CH(CH)) u_gray (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_en   (w_en),
        .i_pix  (w_win[gi]),
        .o_gray (w_g[gi])
      );
    end
  endgenerate

  logic  r_s1_valid, r_s1_sof, r_s1_eol;
  mode_e r_s1_mode;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_mode  <= MODE_LAP8;
      r_mode_q   <= MODE_LAP8;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_s1_sof   <= in_sof;
      r_s1_eol   <= in_eol;
      r_s1_mode  <= w_mode_cur;
      if (w_accept & in_sof)
        r_mode_q <= mode_e'(mode);
    end
  end

  logic signed [ACC_W-1:0] w_s [9];
  logic signed [ACC_W-1:0] w_nsew, w_ring, w_c, w_acc;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++)
      w_s[i] = signed'(ACC_W'(w_g[i]));
    w_c    = w_s[4];
    w_nsew = w_s[1] + w_s[3] + w_s[5] + w_s[7];
    w_ring = w_nsew + w_s[0] + w_s[2] + w_s[6] + w_s[8];
    w_acc  = w_c;
    case (r_s1_mode)
      MODE_LAP8:  w_acc = w_ring - (w_c <<< 3);
      MODE_LAP4:  w_acc = w_nsew - (w_c <<< 2);
      MODE_SHARP: w_acc = (w_c <<< 2) + w_c - w_nsew;
      MODE_PASS:  w_acc = w_c;
      default:    w_acc = w_c;
    endcase
  end

  logic                    r_s2_valid, r_s2_sof, r_s2_eol;
  logic signed [ACC_W-1:0] r_s2_acc;
`ifdef CONV3X3_ABS_EN
  mode_e                   r_s2_mode;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_acc   <= '0;
`ifdef CONV3X3_ABS_EN
      r_s2_mode  <= MODE_LAP8;
`endif
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sof   <= r_s1_sof;
      r_s2_eol   <= r_s1_eol;
      r_s2_acc   <= w_acc;
`ifdef CONV3X3_ABS_EN
      r_s2_mode  <= r_s1_mode;
`endif
    end
  end

  logic signed [ACC_W-1:0] w_mag;
  logic [PIX_W-1:0]        w_pix;

`ifdef CONV3X3_ABS_EN
  assign w_mag = (r_s2_mode != MODE_PASS && r_s2_acc < 0) ? -r_s2_acc : r_s2_acc;
`else
  assign w_mag = r_s2_acc;
`endif
  assign w_pix = PIX_W'(clamp_u({{(ACC_MAX-ACC_W){w_mag[ACC_W-1]}}, w_mag}, PIX_W));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      Dout      <= '0;
    end else if (w_en) begin
      out_valid <= r_s2_valid;
      out_sof   <= r_s2_sof;
      out_eol   <= r_s2_eol;
      Dout      <= {CH{w_pix}};
    end
  end

endmodule

// File: tb/tb_conv3x3_edge_pipe.sv
// Randomised scoreboard bench for conv3x3_edge_pipe against an arithmetic reference of the filter.
module tb_conv3x3_edge_pipe;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [23:0] win [9];
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_ready, out_valid, out_sof, out_eol;
  logic        out_ready = 1'b1;
  logic [23:0] Dout;

  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
  } exp_t;
  exp_t exp_q[$];
  int   mdl_mode = 0;

  always #5 CLK = ~CLK;

  conv3x3_edge_pipe #(.PIX_W(8), .CH(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .D00IN(win[0]), .D01IN(win[1]), .D02IN(win[2]),
    .D10IN(win[3]), .D11IN(win[4]), .D12IN(win[5]),
    .D20IN(win[6]), .D21IN(win[7]), .D22IN(win[8]),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_eol(in_eol),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .Dout(Dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [23:0] ref_pix(input logic [23:0] w [9], input int m);
    int g[9];
    int c, nsew, ring, r;
    for (int i = 0; i < 9; i++)
      g[i] = (int'(w[i][7:0]) + 2 * int'(w[i][15:8]) + int'(w[i][23:16])) / 4;
    c    = g[4];
    nsew = g[1] + g[3] + g[5] + g[7];
    ring = nsew + g[0] + g[2] + g[6] + g[8];
    case (m)
      0:       r = ring - 8 * c;
      1:       r = nsew - 4 * c;
      2:       r = 5 * c - nsew;
      default: r = c;
    endcase
`ifdef CONV3X3_ABS_EN
    if (m != 3 && r < 0) r = -r;
`endif
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
    return {3{8'(r)}};
  endfunction

  logic        held = 1'b0;
  logic [23:0] held_dout;
  logic [1:0]  held_flags;

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      exp_q.delete();
      mdl_mode = 0;
      held     = 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (held && out_valid) begin
        chk("hold_dout", Dout, held_dout);
        chk("hold_flags", {out_sof, out_eol}, held_flags);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("dout", Dout, e.d);
          chk("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
          chk("out_eol", {31'd0, out_eol}, {31'd0, e.eol});
          n_out++;
        end
      end
      held       = out_valid && !out_ready;
      held_dout  = Dout;
      held_flags = {out_sof, out_eol};
      if (in_valid && in_ready) begin
        if (in_sof) mdl_mode = int'(mode);
        exp_q.push_back('{ref_pix(win, mdl_mode), in_sof, in_eol});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_beat(input logic sof, input logic eol, input logic [1:0] m);
    logic acc;
    int   tries;
    in_valid = 1'b1;
    in_sof   = sof;
    in_eol   = eol;
    mode     = m;
    tries    = 0;
    do begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_win(input logic [23:0] c, input logic [23:0] n4, input logic [23:0] cor);
    for (int i = 0; i < 9; i++) win[i] = cor;
    win[1] = n4; win[3] = n4; win[5] = n4; win[7] = n4;
    win[4] = c;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) win[i] = 24'($urandom);
  endtask

  task automatic run_one(input string tag, input logic [23:0] c, input logic [23:0] n4,
                         input logic [23:0] cor, input logic sof, input logic [1:0] m,
                         input logic [23:0] exp_v);
    int k;
    set_win(c, n4, cor);
    drive_beat(sof, 1'b0, m);
    in_valid = 1'b0;
    k = 0;
    while (k < 10) begin
      @(negedge CLK);
      if (out_valid) break;
      k++;
    end
    chk({tag, "_lat"}, k, 2);
    chk(tag, Dout, exp_v);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  logic rnd_bp = 1'b0;
  always @(posedge CLK) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 9; i++) win[i] = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dout", Dout, 32'd0);
    chk("rst_flags", {30'd0, out_sof, out_eol}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Flat gray, strong edges both polarities
    run_one("t1_flat", 24'h808080, 24'h808080, 24'h808080, 1'b1, 2'd0, 24'h000000);
    chk("t1_sof", {31'd0, out_sof}, 32'd1);
    run_one("t2_pos", 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2'd0, 24'hFFFFFF);
`ifdef CONV3X3_ABS_EN
    run_one("t2_neg", 24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 2'd0, 24'hFFFFFF);
    run_one("t3_lap4", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd1, 24'h101010);
`else
    run_one("t2_neg", 24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 2'd0, 24'h000000);
    run_one("t3_lap4", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd1, 24'h000000);
`endif
    run_one("t3_sharp", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd2, 24'h505050);
    run_one("t3_pass", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd3, 24'h404040);

    // Mode latch: non-SOF change ignored, SOF change immediate
    run_one("t4_sof1", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd1,
`ifdef CONV3X3_ABS_EN
            24'h101010);
    run_one("t4_nosof", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b0, 2'd2, 24'h101010);
`else
            24'h000000);
    run_one("t4_nosof", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b0, 2'd2, 24'h000000);
`endif
    run_one("t4_sof2", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b1, 2'd2, 24'h505050);

    // Backpressure: 10 distinct windows, out_ready low for cycles 4-8
    n0 = n_out;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          rand_win();
          drive_beat(b == 0, b == 9, 2'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge CLK);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - n0, 10);

    // Reset with three beats in flight
    n0 = n_out;
    rand_win();
    drive_beat(1'b1, 1'b1, 2'd3);
    rand_win();
    drive_beat(1'b0, 1'b0, 2'd3);
    rand_win();
    drive_beat(1'b0, 1'b1, 2'd3);
    in_valid = 1'b0;
    RESET = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_dout", Dout, 32'd0);
    chk("mrst_flags", {30'd0, out_sof, out_eol}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("mrst_no_stale", n_out - n0, 0);
    chk("mrst_in_ready2", {31'd0, in_ready}, 32'd1);
    run_one("mrst_mode0", 24'h404040, 24'h3C3C3C, 24'h000000, 1'b0, 2'd2,
`ifdef CONV3X3_ABS_EN
            24'hFFFFFF);
`else
            24'h000000);
`endif

    // Random stream with random backpressure
    rnd_bp = 1'b1;
    for (int b = 0; b < 400; b++) begin
      rand_win();
      drive_beat($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
      end
    end
    rnd_bp = 1'b0;
    @(posedge CLK);
    #1 out_ready = 1'b1;
    drain("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_edge_pipe.md
Name: conv3x3_edge_pipe

Overview:
- Parametrised 3x3 grayscale edge/sharpen filter with a valid/ready stream handshake, frame sideband and a per-frame kernel mode.
- Takes a 3x3 window of CH-channel pixels from the line-buffer stage and emits one filtered pixel per accepted window.
- The gray value is replicated across all CH channels.
- Sits between the window generator and the video output formatter.

Parameters:
- PIX_W, 8, bits per colour channel
- CH, 3, channels per pixel (channel 0 = LSBs)
- ACC_W, PIX_W+5, signed accumulator width

Ports:
- CLK  input  1  clock
- RESET  input  1  asynchronous active-low reset
- D00IN,D01IN,D02IN,D10IN,D11IN,D12IN,D20IN,D21IN,D22IN  input  CH*PIX_W each  window pixels; row 0 upper, row 1 middle, row 2 under; D11IN is the centre
- in_valid  input  1  window valid
- in_ready  output  1  block accepts a window this cycle
- in_sof  input  1  window is the first of a frame
- in_eol  input  1  window is the last of a line
- mode  input  2  kernel select; sampled only on SOF beats
- out_valid  output  1  Dout valid
- out_ready  input  1  downstream accepts
- out_sof  output  1  delayed in_sof
- out_eol  output  1  delayed in_eol
- Dout  output  CH*PIX_W  filtered pixel

Behaviour:
- Interface: one clock CLK; RESET is asynchronous, active-low.
- Reset values: all stage valids 0, Dout 0, out_valid 0, out_sof 0, out_eol 0, mode_q 0. in_ready is 1 while in reset and after it.
- Pipeline: three stages S1 gray, S2 kernel, S3 clamp. Each stage carries a valid bit plus sof/eol.
- Global stall: en = ~out_valid | out_ready; in_ready = en (combinational).
  - All stages advance only when en = 1.
  - Accept = in_valid & in_ready.
  - Latency is 3 en-cycles from accept to out_valid.
  - Throughput is 1 window/cycle when out_ready is held high.
  - While out_valid & ~out_ready: Dout, out_sof, out_eol are held stable; no beat is dropped or duplicated; order is preserved.
- S1 gray, per pixel: g = (ch0 + 2*ch1 + ch2) >> 2 for CH >= 3; for CH = 1, g = ch0. Width is PIX_W, unsigned, truncating.
- Mode latch:
  - mode_q <= mode on an accept with in_sof = 1. That same beat already uses the new mode.
  - mode changes on non-SOF beats are ignored.
  - The mode travels with its beat through the pipeline.
- S2 kernel (signed, ACC_W bits; N/S/E/W = g01/g21/g10/g12, c = g11):
  - 0 LAP8: sum of the 8 neighbours - 8*c
  - 1 LAP4: N+S+E+W - 4*c
  - 2 SHARP: 5*c - (N+S+E+W)
  - 3 PASS: c
- S3 clamp: result < 0 gives 0; result > 2^PIX_W-1 gives 2^PIX_W-1; otherwise the low PIX_W bits. The value is replicated CH times on Dout.
- ACC_W guarantees no overflow for any input.
- Reset mid-stream: all in-flight beats are discarded. The first post-reset beat uses mode 0 unless it carries in_sof.
- in_sof and in_eol on the same beat: both are propagated unchanged.

Optional Feature:
- Macro: CONV3X3_ABS_EN.
- Defined: S3 takes |result| before the upper clamp, so negative edges show bright. This applies to modes 0-2 only; mode 3 is unaffected.
- Undefined: negatives clamp to 0 as above.

Decomposition:
- Package conv3x3_pkg:
  - mode localparams MODE_LAP8=0, MODE_LAP4=1, MODE_SHARP=2, MODE_PASS=3
  - the ACC_W default expression
  - a function clamp_u(signed acc) returning PIX_W bits
- One sub-module, conv3x3_gray: registered per-pixel grayscale with enable, instantiated 9 times in S1.
- Kernel math and clamp stay inline.

Test Plan (PIX_W=8, CH=3, out_ready=1 unless stated):
1. mode=0 on SOF beat; all nine pixels 0x808080 -> Dout 0x000000 exactly 3 cycles after accept, out_sof=1 on that beat.
2. mode=0; centre 0x000000, neighbours 0xFFFFFF -> 2040 clamps to Dout 0xFFFFFF. Swapped (centre 0xFFFFFF, neighbours 0x000000) -> Dout 0x000000; with CONV3X3_ABS_EN -> 0xFFFFFF.
3. Centre 0x404040, N/S/E/W 0x3C3C3C, corners 0:
   - mode=1 -> -16 gives 0x000000 (ABS_EN: 0x101010)
   - mode=2 -> 80 gives 0x505050
   - mode=3 -> 0x404040
4. Mode latching: mode changed from 1 to 2 on a non-SOF beat -> still LAP4 results. Mode 2 on the next SOF beat -> SHARP starts on that exact beat.
5. Backpressure: 10 distinct windows streamed, out_ready low for cycles 4-8 -> in_ready low while out_valid & ~out_ready; all 10 outputs appear once, in order; Dout is stable during the stall.
6. RESET asserted with 3 beats in flight -> out_valid, Dout, out_sof, out_eol go to 0 immediately (asynchronous). After release, no stale beats are emitted and in_ready = 1.
